// File: rtl/level_speed_ctrl_pkg.sv
// Shared types and defaults for the level speed controller: state encoding,
// default speed constants and the clamped level-target calculation.
package level_speed_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    BRAKE  = 3'd3,
    STALL  = 3'd4
  } speed_state_t;

  localparam int DEF_BASE_SPEED   = 64;
  localparam int DEF_SPEED_STEP   = 32;
  localparam int DEF_MAX_SPEED    = 256;
  localparam int DEF_ACCEL        = 8;
  localparam int DEF_ACCEL_FRAMES = 2;
  localparam int DEF_BRAKE_DECEL  = 32;
  localparam int DEF_STALL_FRAMES = 4;

  // Unsigned sum first so a large level can never wrap negative before clamping.
  function automatic logic signed [31:0] clamp_target(
    input logic [3:0]  lvl,
    input logic [31:0] base,
    input logic [31:0] step,
    input logic [31:0] max_spd
  );
    logic [31:0] raw;
    raw = base + 32'(lvl) * step;
    return (raw > max_spd) ? signed'(max_spd) : signed'(raw);
  endfunction

endpackage

// File: rtl/level_speed_ctrl_if.sv
// Frame/level control inputs and speed outputs of the level speed controller.
interface level_speed_ctrl_if;
  logic               startOfFrame;
  logic               startOfLevel;
  logic [3:0]         levelNumber;
  logic               collision;
  logic               pause;
  logic signed [31:0] levelSpeed;
  logic signed [31:0] targetSpeed;
  logic               cruising;

  modport master (
    output startOfFrame, startOfLevel, levelNumber, collision, pause,
    input  levelSpeed, targetSpeed, cruising
  );

  modport slave (
    input  startOfFrame, startOfLevel, levelNumber, collision, pause,
    output levelSpeed, targetSpeed, cruising
  );
endinterface

// File: rtl/level_speed_ctrl.sv
// Per-level shared speed generator: ramps to a level target, cruises, brakes
// to zero on a collision, stalls, then ramps again. Updates only on frame ticks.
module level_speed_ctrl
  import level_speed_pkg::*;
#(
  parameter int BASE_SPEED   = DEF_BASE_SPEED,
  parameter int SPEED_STEP   = DEF_SPEED_STEP,
  parameter int MAX_SPEED    = DEF_MAX_SPEED,
  parameter int ACCEL        = DEF_ACCEL,
  parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES,
  parameter int BRAKE_DECEL  = DEF_BRAKE_DECEL,
  parameter int STALL_FRAMES = DEF_STALL_FRAMES
) (
  input logic               clk,
  input logic               resetN,
  level_speed_ctrl_if.slave bus
);

  localparam logic signed [31:0] ACCEL_STEP = 32'(ACCEL);
  localparam logic signed [31:0] BRAKE_STEP = 32'(BRAKE_DECEL);
  localparam logic [31:0]        ACC_LAST   = 32'(ACCEL_FRAMES - 1);
  localparam logic [31:0]        STALL_INIT = 32'(STALL_FRAMES);

  speed_state_t       r_state, w_state_nx;
  logic signed [31:0] r_speed, w_speed_nx;
  logic signed [31:0] r_target, w_target_nx;
  logic [31:0]        r_acc_cnt, w_acc_nx;
  logic [31:0]        r_stall_cnt, w_stall_nx;
  logic               r_hit, w_hit_nx;
  logic               r_cruising;

  logic               w_tick;
  logic               w_do_brake;
  logic signed [31:0] w_acc_raw;
  logic signed [31:0] w_acc_sum;
  logic signed [31:0] w_brk_diff;

  assign w_tick     = bus.startOfFrame & ~bus.pause;
  assign w_acc_raw  = r_speed + ACCEL_STEP;
  assign w_acc_sum  = (w_acc_raw > r_target) ? r_target : w_acc_raw;
  assign w_brk_diff = r_speed - BRAKE_STEP;

  // A pending hit in ACCEL/CRUISE brakes on the very tick that consumes it.
  // The state constant is scoped because the ACCEL parameter shadows it.
  assign w_do_brake = w_tick & ((r_state == BRAKE) |
                      (((r_state == level_speed_pkg::ACCEL) | (r_state == CRUISE)) & r_hit));

  always_comb begin
    w_state_nx  = r_state;
    w_speed_nx  = r_speed;
    w_target_nx = r_target;
    w_acc_nx    = r_acc_cnt;
    w_stall_nx  = r_stall_cnt;
    w_hit_nx    = r_hit;

    if (bus.startOfLevel) begin
      w_target_nx = clamp_target(bus.levelNumber, 32'(BASE_SPEED), 32'(SPEED_STEP), 32'(MAX_SPEED));
      w_speed_nx  = '0;
      w_acc_nx    = '0;
      w_hit_nx    = 1'b0;
      w_state_nx  = level_speed_pkg::ACCEL;
    end else if (w_do_brake) begin
      w_hit_nx = 1'b0;
      if (w_brk_diff <= 32'sd0) begin
        w_speed_nx = '0;
        w_state_nx = STALL;
        w_stall_nx = STALL_INIT;
      end else begin
        w_speed_nx = w_brk_diff;
        w_state_nx = BRAKE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_speed_nx = '0;
          w_hit_nx   = 1'b0;
        end
        level_speed_pkg::ACCEL: begin
          w_hit_nx = r_hit | bus.collision;
          if (w_tick) begin
            if (r_acc_cnt >= ACC_LAST) begin
              w_acc_nx   = '0;
              w_speed_nx = w_acc_sum;
              if (w_acc_sum == r_target) w_state_nx = CRUISE;
            end else begin
              w_acc_nx = r_acc_cnt + 32'd1;
            end
          end
        end
        CRUISE: w_hit_nx = r_hit | bus.collision;
        BRAKE:  w_hit_nx = 1'b0;
        STALL: begin
          w_hit_nx = 1'b0;
          if (w_tick) begin
            if (r_stall_cnt <= 32'd1) begin
              w_stall_nx = '0;
              w_acc_nx   = '0;
              w_state_nx = level_speed_pkg::ACCEL;
            end else begin
              w_stall_nx = r_stall_cnt - 32'd1;
            end
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_speed_nx = '0;
          w_hit_nx   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_speed     <= '0;
      r_target    <= '0;
      r_acc_cnt   <= '0;
      r_stall_cnt <= '0;
      r_hit       <= 1'b0;
      r_cruising  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_speed     <= w_speed_nx;
      r_target    <= w_target_nx;
      r_acc_cnt   <= w_acc_nx;
      r_stall_cnt <= w_stall_nx;
      r_hit       <= w_hit_nx;
      r_cruising  <= (w_state_nx == CRUISE);
    end
  end

  assign bus.levelSpeed  = r_speed;
  assign bus.targetSpeed = r_target;
  assign bus.cruising    = r_cruising;

endmodule

// File: tb/tb_level_speed_ctrl.sv
// Self-checking bench for level_speed_ctrl: table vectors, directed corner
// sequences and randomized traffic against a tick-counting reference model.
module tb_level_speed_ctrl;

  localparam int T_BASE  = 64;
  localparam int T_STEP  = 32;
  localparam int T_MAX   = 256;
  localparam int T_ACC   = 8;
  localparam int T_AF    = 2;
  localparam int T_DEC   = 32;
  localparam int T_STALL = 4;

  localparam int M_IDLE = 0, M_ACCEL = 1, M_CRUISE = 2, M_BRAKE = 3, M_STALL = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  level_speed_ctrl_if bus();
  level_speed_ctrl dut (.clk(clk), .resetN(resetN), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_mode, m_speed, m_target, m_ticks, m_stall_left;
  bit m_hit, m_cruise;

  typedef struct {
    logic       sof;
    logic       sol;
    logic [3:0] lvl;
    logic       col;
    logic       pau;
    int         e_spd;
    int         e_tgt;
    logic       e_cr;
  } vec_t;
  vec_t tbl[19];

  function automatic void model_reset();
    m_mode = M_IDLE; m_speed = 0; m_target = 0; m_ticks = 0;
    m_stall_left = 0; m_hit = 1'b0; m_cruise = 1'b0;
  endfunction

  function automatic void model_brake();
    m_speed = (m_speed > T_DEC) ? m_speed - T_DEC : 0;
    m_hit = 1'b0;
    if (m_speed == 0) begin
      m_mode = M_STALL;
      m_stall_left = T_STALL;
    end else begin
      m_mode = M_BRAKE;
    end
  endfunction

  function automatic void model_clock(logic sof, logic sol, logic [3:0] lvl, logic col, logic pau);
    bit tick;
    int raw;
    tick = sof && !pau;
    if (sol) begin
      raw = T_BASE + int'(lvl) * T_STEP;
      m_target = (raw > T_MAX) ? T_MAX : raw;
      m_speed = 0; m_ticks = 0; m_hit = 1'b0; m_mode = M_ACCEL;
    end else begin
      case (m_mode)
        M_ACCEL, M_CRUISE: begin
          if (tick && m_hit) model_brake();
          else begin
            if (col) m_hit = 1'b1;
            if (tick && m_mode == M_ACCEL) begin
              m_ticks++;
              if (m_ticks % T_AF == 0) begin
                m_speed = (m_speed + T_ACC > m_target) ? m_target : m_speed + T_ACC;
                if (m_speed == m_target) m_mode = M_CRUISE;
              end
            end
          end
        end
        M_BRAKE: begin
          m_hit = 1'b0;
          if (tick) model_brake();
        end
        M_STALL: begin
          m_hit = 1'b0;
          if (tick) begin
            m_stall_left--;
            if (m_stall_left == 0) begin
              m_mode = M_ACCEL;
              m_ticks = 0;
            end
          end
        end
        default: begin
          m_hit = 1'b0;
          m_speed = 0;
        end
      endcase
    end
    m_cruise = (m_mode == M_CRUISE);
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int es, input int et, input int ec);
    chk({tag, ".levelSpeed"}, bus.levelSpeed, es);
    chk({tag, ".targetSpeed"}, bus.targetSpeed, et);
    chk({tag, ".cruising"}, {31'd0, bus.cruising}, ec);
  endtask

  task automatic clk_step();
    @(posedge clk);
    if (resetN) model_clock(bus.startOfFrame, bus.startOfLevel, bus.levelNumber, bus.collision, bus.pause);
    else model_reset();
    #1;
    chk_all("model", m_speed, m_target, int'(m_cruise));
  endtask

  task automatic idle_inputs();
    bus.startOfFrame = 1'b0; bus.startOfLevel = 1'b0; bus.levelNumber = 4'd0;
    bus.collision = 1'b0; bus.pause = 1'b0;
  endtask

  // One frame tick followed by a quiet cycle
  task automatic tick();
    bus.startOfFrame = 1'b1;
    clk_step();
    bus.startOfFrame = 1'b0;
    clk_step();
  endtask

  task automatic start_level(input logic [3:0] lvl);
    bus.startOfLevel = 1'b1; bus.levelNumber = lvl;
    clk_step();
    bus.startOfLevel = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();

    tbl = '{
      '{1'b0, 1'b1, 4'd2,  1'b0, 1'b0,   0, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   0, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   8, 128, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0,   8, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1,   8, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   8, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,  16, 128, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0,  16, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   0, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0,   0, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   0, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   0, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   0, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   0, 128, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   8, 128, 1'b0},
      '{1'b1, 1'b1, 4'd15, 1'b0, 1'b0,   0, 256, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   0, 256, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0,   8, 256, 1'b0},
      '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0,   0,  64, 1'b0}
    };

    // Reset state
    resetN = 1'b0;
    repeat (3) clk_step();
    chk_all("reset", 0, 0, 0);
    resetN = 1'b1;
    clk_step();
    chk_all("idle", 0, 0, 0);

    // Table vectors, one clock each
    for (int i = 0; i < 19; i++) begin
      bus.startOfFrame = tbl[i].sof; bus.startOfLevel = tbl[i].sol;
      bus.levelNumber = tbl[i].lvl; bus.collision = tbl[i].col; bus.pause = tbl[i].pau;
      clk_step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_spd, tbl[i].e_tgt, int'(tbl[i].e_cr));
    end
    idle_inputs();

    // Level 2 ramp to cruise
    start_level(4'd2);
    chk_all("l2_start", 0, 128, 0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("l2_ramp%0d", k), bus.levelSpeed, 8 * (k / 2));
      chk($sformatf("l2_cr%0d", k), {31'd0, bus.cruising}, (k == 32) ? 1 : 0);
    end

    // Collision in cruise: brake, stall, re-accelerate
    bus.collision = 1'b1; clk_step(); bus.collision = 1'b0;
    chk_all("hit_hold", 128, 128, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all($sformatf("brake%0d", k), 128 - 32 * k, 128, 0);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all($sformatf("stall%0d", k), 0, 128, 0);
    end
    tick(); chk_all("reacc1", 0, 128, 0);
    tick(); chk_all("reacc2", 8, 128, 0);

    // Collision while paused takes effect on the first unpaused tick
    start_level(4'd2);
    repeat (32) tick();
    chk_all("cruise_again", 128, 128, 1);
    bus.pause = 1'b1;
    bus.collision = 1'b1; clk_step(); bus.collision = 1'b0;
    repeat (5) tick();
    chk_all("paused", 128, 128, 1);
    bus.pause = 1'b0;
    tick(); chk_all("unpause_brake", 96, 128, 0);
    tick(); chk_all("brake_64", 64, 128, 0);

    // startOfLevel beats a coincident frame tick in BRAKE
    bus.startOfLevel = 1'b1; bus.levelNumber = 4'd0; bus.startOfFrame = 1'b1;
    clk_step();
    idle_inputs();
    chk_all("sol_in_brake", 0, 64, 0);
    tick(); chk_all("sol_acc1", 0, 64, 0);
    tick(); chk_all("sol_acc2", 8, 64, 0);

    // Level 15 clamps to 256 and cruises after 64 ticks
    start_level(4'd15);
    chk_all("l15_start", 0, 256, 0);
    repeat (63) tick();
    chk_all("l15_t63", 248, 256, 0);
    tick();
    chk_all("l15_t64", 256, 256, 1);

    // Asynchronous reset in the middle of ACCEL
    start_level(4'd3);
    repeat (5) tick();
    resetN = 1'b0;
    #1;
    model_reset();
    chk_all("async_reset", 0, 0, 0);
    clk_step(); clk_step();
    resetN = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk_all("post_reset_idle", 0, 0, 0);

    // Randomized traffic against the model
    start_level(4'($urandom_range(0, 15)));
    for (int i = 0; i < 4000; i++) begin
      bus.startOfFrame = ($urandom_range(0, 3) == 0);
      bus.startOfLevel = ($urandom_range(0, 299) == 0);
      bus.levelNumber  = 4'($urandom_range(0, 15));
      bus.collision    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) bus.pause = ~bus.pause;
      resetN = ($urandom_range(0, 1999) != 0);
      clk_step();
      resetN = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
